// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver with valid/ready byte handoff, framing-error and overrun pulses.
// Define SVC_UART_RX_SYNC_EN to pass urx_pin through a 2-flop synchronizer (+2 cycles latency).
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_pin,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("svc_uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          rx_s;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          expire;

`ifdef SVC_UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], urx_pin};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = urx_pin;
`endif

  // Timer counts down to 1; the edge that sees 1 is the sampling edge.
  assign expire = (timer == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      urx_valid     <= 1'b0;
      urx_data      <= '0;
      urx_frame_err <= 1'b0;
      urx_overrun   <= 1'b0;
    end else begin
      urx_frame_err <= 1'b0;
      urx_overrun   <= 1'b0;
      if (urx_valid && urx_ready) begin
        urx_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            timer <= TW'(HALF_BIT);
          end
        end
        S_START: begin
          if (expire) begin
            if (!rx_s) begin
              state   <= S_DATA;
              timer   <= TW'(CLKS_PER_BIT);
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
              timer <= '0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DATA: begin
          if (expire) begin
            shreg[bit_idx] <= rx_s;
            timer          <= TW'(CLKS_PER_BIT);
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_STOP: begin
          if (expire) begin
            state <= S_IDLE;
            timer <= '0;
            if (!rx_s) begin
              urx_frame_err <= 1'b1;
            end else if (urx_valid && !urx_ready) begin
              urx_overrun <= 1'b1;
            end else begin
              // Overrides the accept-clear above when completion coincides with an accept.
              urx_valid <= 1'b1;
              urx_data  <= shreg;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
